// File: rtl/pc_fetch_controller.sv
// PC generation and instruction-fetch request control.
// Tracks one outstanding request and discards responses made stale by redirects.
module pc_fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             CPU_CLK,
  input  logic             CPU_RST_N,
  input  logic             BranchE,
  input  logic [31:0]      BranchTarget,
  input  logic             JalrE,
  input  logic [31:0]      JalrTarget,
  input  logic             JalD,
  input  logic [31:0]      JalTarget,
  input  logic             StallF,
  input  logic             IAck,
  output logic             IReq,
  output logic [31:0]      IAddr,
  output logic [31:0]      PCF,
  output logic             InstrValidF,
  output logic             RedirectF,
  output logic [CNT_W-1:0] KillCnt
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] KILL  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state, state_nx;
  logic [31:0]      pc, pc_nx;
  logic [31:0]      req, req_nx;
  logic [31:0]      pc_inc;
  logic [31:0]      tgt;
  logic [CNT_W-1:0] kcnt;
  logic             redirect;
  logic             kill_inc;
  logic             ireq_s;
  logic             valid_s;

  assign redirect = BranchE | JalrE | JalD;
  assign pc_inc   = pc + 32'd4;

  always_comb begin
    tgt = JalTarget;
    if (BranchE)
      tgt = BranchTarget;
    else if (JalrE)
      tgt = {JalrTarget[31:1], 1'b0};
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    req_nx   = req;
    kill_inc = 1'b0;
    ireq_s   = 1'b0;
    valid_s  = 1'b0;
    unique case (state)
      HOLD: begin
        valid_s = ~redirect;
        if (redirect) begin
          pc_nx    = tgt;
          req_nx   = tgt;
          kill_inc = 1'b1;
          state_nx = FETCH;
        end else if (!StallF) begin
          pc_nx    = pc_inc;
          req_nx   = pc_inc;
          state_nx = FETCH;
        end
      end
      KILL: begin
        ireq_s = 1'b1;
        if (redirect)
          pc_nx = tgt;
        if (IAck) begin
          kill_inc = 1'b1;
          req_nx   = redirect ? tgt : pc;
          state_nx = FETCH;
        end
      end
      default: begin
        ireq_s  = 1'b1;
        valid_s = IAck & ~redirect;
        if (redirect) begin
          pc_nx = tgt;
          if (IAck) begin
            req_nx   = tgt;
            kill_inc = 1'b1;
          end else begin
            state_nx = KILL;
          end
        end else if (IAck) begin
          if (StallF) begin
            state_nx = HOLD;
          end else begin
            pc_nx  = pc_inc;
            req_nx = pc_inc;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      state <= FETCH;
      pc    <= RESET_PC;
      req   <= RESET_PC;
      kcnt  <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      req   <= req_nx;
      if (kill_inc && !(&kcnt))
        kcnt <= kcnt + CNT_ONE;
    end
  end

  // Reset gates the request so memory never sees one mid-reset.
  assign IReq        = CPU_RST_N & ireq_s;
  assign IAddr       = req;
  assign PCF         = pc;
  assign InstrValidF = valid_s;
  assign RedirectF   = redirect;
  assign KillCnt     = kcnt;

endmodule
